// File: rtl/lsq_ram_cfg.sv
// lsq_ram_cfg -- parametrised multi-port LSQ storage RAM with per-partition
// power gating and a self-clearing sweep engine.
//
// Ports:
//   clk                rising-edge clock
//   reset              asynchronous active-low reset
//   addr_i / data_o    NUM_RD_PORTS combinational read ports
//   addrWr_i/dataWr_i  NUM_WR_PORTS synchronous write ports, gated by wrEn_i
//   partitionActive_i  per-partition power state (1 = powered)
//   ramReady_o         high when no partition clear is pending or running
//
// Optional feature macro: LSQ_RAM_WR_BYPASS_EN
//   defined     -> a read hitting an accepted same-cycle write returns the
//                  write data (highest-numbered write port wins)
//   not defined -> reads return the pre-write array contents
//
// Whenever a partition powers up its contents are unknown, so it is marked
// pending and reads 0 until the sweep has zeroed every entry in it. The
// array itself has no reset; only the sweep clears it.
module lsq_ram_cfg #(
   parameter int DEPTH         = 32,
   parameter int INDEX         = 5,
   parameter int WIDTH         = 8,
   parameter int NUM_RD_PORTS  = 2,
   parameter int NUM_WR_PORTS  = 2,
   parameter int NUM_PARTS     = 4,
   parameter int NUM_PARTS_LOG = 2
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_RD_PORTS-1:0][INDEX-1:0]      addr_i,
   output logic [NUM_RD_PORTS-1:0][WIDTH-1:0]      data_o,
   input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]      addrWr_i,
   input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]      dataWr_i,
   input  logic [NUM_WR_PORTS-1:0]                 wrEn_i,
   input  logic [NUM_PARTS-1:0]                    partitionActive_i,
   output logic                                    ramReady_o
);

   localparam int PART_DEPTH = DEPTH / NUM_PARTS;
   localparam int PTR_W      = INDEX - NUM_PARTS_LOG;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PART_DEPTH - 1);

   typedef enum logic {ST_READY, ST_CLEAR} state_t;

   state_t                     state_q, state_d;
   logic [PTR_W-1:0]           ptr_q, ptr_d;
   logic [NUM_PARTS_LOG-1:0]   part_q, part_d;
   logic [NUM_PARTS-1:0]       pending_q, pending_d;
   logic [NUM_PARTS-1:0]       act_q, act_d;
   logic [WIDTH-1:0]           mem_q [DEPTH];
   logic [WIDTH-1:0]           mem_d [DEPTH];
   logic                       clr_en;
   logic                       advance;
   logic [NUM_WR_PORTS-1:0]    wr_ok;

   function automatic logic [NUM_PARTS_LOG-1:0] lowest(input logic [NUM_PARTS-1:0] v);
      lowest = '0;
      for (int i = NUM_PARTS - 1; i >= 0; i--)
         if (v[i]) lowest = NUM_PARTS_LOG'(i);
   endfunction

   assign act_d      = partitionActive_i;
   assign ramReady_o = (state_q == ST_READY) && (pending_q == '0);

   // Sweep FSM. pending_d already reflects this cycle's gating and power-up
   // edges, so a newly powered partition is picked up on the same edge.
   always_comb begin
      pending_d = (pending_q & partitionActive_i) | (partitionActive_i & ~act_q);
      state_d   = state_q;
      ptr_d     = ptr_q;
      part_d    = part_q;
      clr_en    = 1'b0;
      advance   = 1'b0;
      case (state_q)
         ST_READY: begin
            if (pending_d != '0) begin
               state_d = ST_CLEAR;
               part_d  = lowest(pending_d);
               ptr_d   = '0;
            end
         end
         ST_CLEAR: begin
            if (!partitionActive_i[part_q]) begin
               // partition lost power mid-sweep: abandon it
               advance = 1'b1;
            end else begin
               clr_en = 1'b1;
               ptr_d  = ptr_q + PTR_W'(1);
               if (ptr_q == PTR_LAST) begin
                  pending_d[part_q] = 1'b0;
                  advance           = 1'b1;
               end
            end
         end
         default: state_d = ST_CLEAR;
      endcase
      if (advance) begin
         ptr_d = '0;
         if (pending_d != '0) begin
            state_d = ST_CLEAR;
            part_d  = lowest(pending_d);
         end else begin
            state_d = ST_READY;
         end
      end
   end

   // Writes only land in a powered partition while nothing is being cleared.
   always_comb begin
      wr_ok = '0;
      for (int w = 0; w < NUM_WR_PORTS; w++)
         wr_ok[w] = wrEn_i[w] && ramReady_o &&
                    partitionActive_i[addrWr_i[w][INDEX-1 -: NUM_PARTS_LOG]];
   end

   // Later ports overwrite earlier ones, so the highest port wins a collision.
   always_comb begin
      mem_d = mem_q;
      if (clr_en) mem_d[{part_q, ptr_q}] = '0;
      for (int w = 0; w < NUM_WR_PORTS; w++)
         if (wr_ok[w]) mem_d[addrWr_i[w]] = dataWr_i[w];
   end

   always_comb begin
      data_o = '0;
      for (int r = 0; r < NUM_RD_PORTS; r++) begin
         if (partitionActive_i[addr_i[r][INDEX-1 -: NUM_PARTS_LOG]] &&
             !pending_q[addr_i[r][INDEX-1 -: NUM_PARTS_LOG]]) begin
            data_o[r] = mem_q[addr_i[r]];
`ifdef LSQ_RAM_WR_BYPASS_EN
            for (int w = 0; w < NUM_WR_PORTS; w++)
               if (wr_ok[w] && (addrWr_i[w] == addr_i[r])) data_o[r] = dataWr_i[w];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_CLEAR;
         ptr_q     <= '0;
         part_q    <= '0;
         pending_q <= '1;
         act_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         part_q    <= part_d;
         pending_q <= pending_d;
         act_q     <= act_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_lsq_ram_cfg.sv
module tb_lsq_ram_cfg;
   localparam int DEPTH = 32;
   localparam int NP    = 4;
   localparam int PD    = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0][4:0] rd_addr = '0;
   logic [1:0][7:0] rd_data;
   logic [1:0][4:0] wr_addr = '0;
   logic [1:0][7:0] wr_data = '0;
   logic [1:0]      wr_en = '0;
   logic [3:0]      act = 4'hF;
   logic            ready;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lsq_ram_cfg dut (
      .clk(clk), .reset(rst_n),
      .addr_i(rd_addr), .data_o(rd_data),
      .addrWr_i(wr_addr), .dataWr_i(wr_data), .wrEn_i(wr_en),
      .partitionActive_i(act), .ramReady_o(ready)
   );

   // Behavioural model: a set of partitions owed a clear, the one currently
   // being cleared and how many cycles it still needs. A partition's data is
   // zeroed in one go when its clear completes; reads of pending partitions
   // are 0 anyway, so that is observationally the same.
   logic [7:0] m_mem [DEPTH];
   logic [3:0] m_pend;
   logic [3:0] m_actp;
   int         m_cur;
   int         m_left;

   function automatic bit m_ready();
      return (m_cur < 0) && (m_pend == 4'h0);
   endfunction

   task automatic m_reset();
      m_pend = 4'hF;
      m_cur  = 0;
      m_left = PD;
      m_actp = 4'h0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
   endtask

   task automatic m_step();
      bit         rdy;
      logic [3:0] rise;
      rdy  = m_ready();
      rise = act & ~m_actp;
      if (rdy)
         for (int w = 0; w < 2; w++)
            if (wr_en[w] && act[wr_addr[w][4:3]]) m_mem[wr_addr[w]] = wr_data[w];
      m_pend = (m_pend & act) | rise;
      if (m_cur >= 0) begin
         if (!act[m_cur]) m_cur = -1;
         else begin
            m_left--;
            if (m_left == 0) begin
               m_pend[m_cur] = 1'b0;
               for (int i = 0; i < PD; i++) m_mem[m_cur*PD + i] = 8'h00;
               m_cur = -1;
            end
         end
      end
      if (m_cur < 0 && m_pend != 4'h0) begin
         for (int p = NP - 1; p >= 0; p--) if (m_pend[p]) m_cur = p;
         m_left = PD;
      end
      m_actp = act;
   endtask

   function automatic logic [7:0] exp_rd(input logic [4:0] a);
      logic [7:0] v;
      v = 8'h00;
      if (act[a[4:3]] && !m_pend[a[4:3]]) begin
         v = m_mem[a];
`ifdef LSQ_RAM_WR_BYPASS_EN
         if (m_ready())
            for (int w = 0; w < 2; w++)
               if (wr_en[w] && act[wr_addr[w][4:3]] && wr_addr[w] == a) v = wr_data[w];
`endif
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   // model compare, every cycle, half a period away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         chk("ready", {31'd0, ready}, {31'd0, m_ready()});
         for (int r = 0; r < 2; r++) chk("rd", {24'd0, rd_data[r]}, {24'd0, exp_rd(rd_addr[r])});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic count_low(output int n);
      n = 0;
      while (!ready && n < 200) begin
         cyc();
         n++;
      end
   endtask

`ifdef LSQ_RAM_WR_BYPASS_EN
   localparam logic [7:0] BYP5 = 8'h55;
`else
   localparam logic [7:0] BYP5 = 8'h00;
`endif

   initial begin
      int n;
      repeat (3) cyc();
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_rd0", {24'd0, rd_data[0]}, 32'd0);
      chk("reset_rd1", {24'd0, rd_data[1]}, 32'd0);
      rst_n = 1'b1;

      // initial sweep, with a write attempted mid-sweep that must be dropped
      n = 0;
      while (!ready && n < 200) begin
         cyc();
         n++;
         if (n == 3) begin
            wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 8'h3C;
         end else wr_en = 2'b00;
      end
      wr_en = 2'b00;
      chk("init_clear_len", n, 32'd32);
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr[0] = 5'(a); rd_addr[1] = 5'(31 - a);
         #1;
         chk("init_zero", {24'd0, rd_data[0]}, 32'd0);
      end
      rd_addr[0] = 5'd9; #1;
      chk("drop_9", {24'd0, rd_data[0]}, 32'd0);

      // same-address collision: port 1 wins
      cyc();
      wr_en = 2'b11; wr_addr[0] = 5'd5; wr_addr[1] = 5'd5;
      wr_data[0] = 8'hAA; wr_data[1] = 8'h55; rd_addr[0] = 5'd5;
      #1;
      chk("bypass5", {24'd0, rd_data[0]}, {24'd0, BYP5});
      cyc();
      wr_en = 2'b00; #1;
      chk("wr5", {24'd0, rd_data[0]}, 32'h55);

      // two different addresses in one cycle
      wr_en = 2'b11; wr_addr[0] = 5'd0; wr_data[0] = 8'h12;
      wr_addr[1] = 5'd31; wr_data[1] = 8'h9E;
      cyc();
      wr_en = 2'b00; rd_addr[0] = 5'd0; rd_addr[1] = 5'd31; #1;
      chk("wr0", {24'd0, rd_data[0]}, 32'h12);
      chk("wr31", {24'd0, rd_data[1]}, 32'h9E);

      // partition 2 gating and re-activation
      wr_en = 2'b01; wr_addr[0] = 5'd20; wr_data[0] = 8'h77;
      cyc();
      wr_en = 2'b00; rd_addr[1] = 5'd20; #1;
      chk("fill20", {24'd0, rd_data[1]}, 32'h77);
      act[2] = 1'b0;
      cyc(); #1;
      chk("gated20", {24'd0, rd_data[1]}, 32'd0);
      wr_en = 2'b01; wr_addr[0] = 5'd20; wr_data[0] = 8'h11;
      cyc();
      wr_en = 2'b00;
      act[2] = 1'b1;
      cyc(); #1;
      chk("react_fall", {31'd0, ready}, 32'd0);
      count_low(n);
      chk("react2_len", n, 32'd8);
      #1;
      chk("cleared20", {24'd0, rd_data[1]}, 32'd0);
      rd_addr[0] = 5'd5; #1;
      chk("keep5", {24'd0, rd_data[0]}, 32'h55);

      // partitions 1 and 3 together
      act = 4'b0101;
      cyc();
      act = 4'hF;
      cyc();
      count_low(n);
      chk("react13_len", n, 32'd16);

      // again, dropping partition 3 while partition 1 is being cleared
      act = 4'b0101;
      cyc();
      act = 4'hF;
      cyc();
      n = 0;
      while (!ready && n < 200) begin
         cyc();
         n++;
         if (n == 3) act[3] = 1'b0;
      end
      chk("react1_drop3_len", n, 32'd8);
      act[3] = 1'b1;
      cyc();
      count_low(n);
      chk("react3_len", n, 32'd8);

      // reset in the middle of a sweep restarts the full clear
      wr_en = 2'b01; wr_addr[0] = 5'd12; wr_data[0] = 8'h5A;
      cyc();
      wr_en = 2'b00; rd_addr[0] = 5'd12; #1;
      chk("fill12", {24'd0, rd_data[0]}, 32'h5A);
      act[0] = 1'b0;
      cyc();
      act[0] = 1'b1;
      cyc();
      repeat (4) cyc();
      rst_n = 1'b0; #1;
      chk("midreset_ready", {31'd0, ready}, 32'd0);
      chk("midreset_rd", {24'd0, rd_data[0]}, 32'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      count_low(n);
      chk("reclear_len", n, 32'd32);
      #1;
      chk("reclear12", {24'd0, rd_data[0]}, 32'd0);
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lsq_ram_cfg.md
# lsq_ram_cfg

Parametrised multi-port LSQ storage RAM with per-partition power gating and a self-clearing sweep engine. It succeeds the fixed two-read/two-write store-queue RAM. Port counts, depth, width and partition count are generic, and partition clearing is handled internally instead of by an external RAM wrapper. It sits inside the LSQ (store/load data and address arrays) and gates LSQ dispatch via `ramReady_o`.

## Interface
- `DEPTH`, 32, total entries; must be a multiple of `NUM_PARTS`
- `INDEX`, 5, address width; equals log2(`DEPTH`)
- `WIDTH`, 8, entry width in bits
- `NUM_RD_PORTS`, 2, combinational read ports
- `NUM_WR_PORTS`, 2, synchronous write ports
- `NUM_PARTS`, 4, partitions; `PART_DEPTH` = `DEPTH`/`NUM_PARTS`
- `NUM_PARTS_LOG`, 2, log2(`NUM_PARTS`)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `addr_i`  in  [NUM_RD_PORTS][INDEX]  read addresses
- `data_o`  out  [NUM_RD_PORTS][WIDTH]  read data
- `addrWr_i`  in  [NUM_WR_PORTS][INDEX]  write addresses
- `dataWr_i`  in  [NUM_WR_PORTS][WIDTH]  write data
- `wrEn_i`  in  [NUM_WR_PORTS]  write enables
- `partitionActive_i`  in  [NUM_PARTS]  1 = partition powered
- `ramReady_o`  out  1  high when no clear is pending or in progress

## Operation
- Partition of an address = `addr[INDEX-1 -: NUM_PARTS_LOG]`.
- Control state holds FSM state, sweep pointer, current partition, `pending[NUM_PARTS]` and a registered copy of `partitionActive_i`. The array has no reset and is cleared only by the sweep.
- Reset sets state CLEAR, pointer 0, and `pending` to all ones.
- Every cycle: `pending &= partitionActive_i`. A rising edge on `partitionActive_i[p]` (registered vs current) sets `pending[p]`.
- FSM:
  - **READY**: if `pending != 0`, go to CLEAR and select the lowest-index pending partition, pointer 0.
  - **CLEAR**: write zero to entry `{part, ptr}` and increment `ptr`. At `ptr == PART_DEPTH-1`, clear `pending[part]`, then pick the next lowest pending partition or go to READY.
  - If the current partition goes inactive mid-sweep, abort it on that edge and pick the next pending partition or go to READY.
- `ramReady_o` = (state == READY) && (`pending` == 0).
- Writes:
  - Accepted only when `ramReady_o` = 1 and the target partition is active.
  - Otherwise the write is silently dropped.
  - If two or more ports write the same address in one cycle, the highest-numbered port wins.
- Reads: `data_o[r]` = 0 if the addressed partition is inactive or pending; otherwise it is the stored entry.

## Timing
- Reads are combinational and have zero latency. Writes become visible on the cycle after the write edge (unless bypass is enabled, see Configuration).
- Clear: one entry per cycle.
  - With all partitions active, `ramReady_o` rises after exactly `DEPTH` rising edges following reset release.
  - Re-activating one partition takes `PART_DEPTH` cycles. `ramReady_o` falls on the edge after the rising edge of `partitionActive_i` is sampled.
- Reset values: `ramReady_o` = 0; all `data_o` = 0, because every partition is pending.
- Reset asserted mid-sweep restarts the full clear.
- Deactivation and reactivation of a partition in the same cycle cannot occur; toggles are registered.

## Configuration
- `LSQ_RAM_WR_BYPASS_EN`:
  - **Defined**: a read whose address matches an accepted write in the same cycle returns that write's data combinationally. If multiple writes match, the highest-numbered write port wins.
  - **Not defined**: the read returns the pre-write array contents.
  - Gated or pending partitions still read 0 in both cases.

## Test plan
- Release reset with all 4 partitions active: `ramReady_o` = 0 for 32 cycles, then 1. Every address reads 0.
- Ports 0 and 1 both write address 5 with 0xAA and 0x55 in one cycle: address 5 reads 0x55 next cycle. A read of address 5 during the write cycle returns 0x55 with bypass, or 0x00 without.
- Write 0x3C to address 9 while `ramReady_o` = 0 during the initial sweep: the write is dropped, and address 9 reads 0 once ready.
- Fill address 20 = 0x77, drop then raise `partitionActive_i[2]`:
  - While low: reads of address 20 return 0 and writes are dropped.
  - After rise: `ramReady_o` is low for 8 cycles, then address 20 reads 0.
- Re-activate partitions 1 and 3 together: partition 1 clears first, then partition 3; ready after 16 cycles. Lowering partition 3 during partition 1's sweep gives ready after 8 cycles.
- Assert `reset` mid-sweep at pointer 4: on release, the full 32-cycle clear restarts and `ramReady_o` stays 0 throughout.
